// File: rtl/reaction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_pkg
// Description : Shared types and default constants for the reaction timer.
//               Defines the controller state type and the default
//               millisecond-count width and ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_pkg;

    // Default sizing: 14 bits holds the 9999 ms ceiling.
    localparam int C_MS_W     = 14;
    localparam int C_MAX_MS   = 9999;
    localparam int C_TICK_DIV = 100000;

    // Round state of the controller.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        GO      = 3'd2,
        DONE    = 3'd3,
        EARLY   = 3'd4,
        TIMEOUT = 3'd5
    } state_t;

endpackage : reaction_pkg
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_gen
// Description : Millisecond tick generator. Counts enabled clk cycles and
//               emits a single-cycle tick on every TICK_DIV-th enabled cycle.
//               clr restarts the count from zero.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-low reset
//               clr  - synchronous restart of the cycle count
//               en   - count enable
//               tick - one-cycle pulse on the last cycle of each period
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // Guard against a zero-width counter when TICK_DIV is 1.
    localparam int             C_CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(TICK_DIV - 1);

    logic [C_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Tick marks the final cycle of a period so the consumer can bump its
    // millisecond count on the same edge the tick counter wraps.
    assign tick = en && !clr && w_wrap;

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/reaction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_ctrl
// Description : Top-level controller of the human reaction timer. Requests a
//               random wait, lights GO when it completes, and measures the
//               player's reaction in milliseconds. Flags false starts and
//               timeouts.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous active-low reset
//               btn_start   - single-cycle start pulse
//               btn_react   - single-cycle reaction pulse
//               r_waitdone  - random wait complete
//               start_rwait - random-wait request, high only in WAIT
//               led_go      - GO indicator, high only in GO
//               rt_ms       - last measured reaction time (ms)
//               rt_valid    - rt_ms holds a valid result
//               early       - false start flagged
//               timeout     - MAX_MS reached without reaction
//               busy        - high in WAIT or GO
//               best_ms     - best valid reaction time
// Options     : REACTION_BEST_TIME_EN - when defined, best_ms tracks the
//               minimum captured reaction time; otherwise it is tied to
//               MAX_MS.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = C_TICK_DIV,
    parameter int MAX_MS   = C_MAX_MS,
    parameter int MS_W     = C_MS_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_start,
    input  logic            btn_react,
    input  logic            r_waitdone,
    output logic            start_rwait,
    output logic            led_go,
    output logic [MS_W-1:0] rt_ms,
    output logic            rt_valid,
    output logic            early,
    output logic            timeout,
    output logic            busy,
    output logic [MS_W-1:0] best_ms
);

    localparam logic [MS_W-1:0] C_MAX = MS_W'(MAX_MS);

    state_t          r_state;
    logic [MS_W-1:0] r_ms_cnt;
    logic            w_tick;
    logic            w_in_go;

    assign w_in_go = (r_state == GO);

    // Tick counter is held cleared outside GO, so it always starts from
    // zero on the first GO cycle.
    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!w_in_go),
        .en   (w_in_go),
        .tick (w_tick)
    );

    // Completed milliseconds since GO entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ms_cnt <= '0;
        end else if (!w_in_go) begin
            r_ms_cnt <= '0;
        end else if (w_tick && (r_ms_cnt != C_MAX)) begin
            r_ms_cnt <= r_ms_cnt + 1'b1;
        end
    end

    // Round FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            start_rwait <= 1'b0;
            led_go      <= 1'b0;
            rt_ms       <= '0;
            rt_valid    <= 1'b0;
            early       <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE, EARLY, TIMEOUT: begin
                    if (btn_start) begin
                        r_state     <= WAIT;
                        start_rwait <= 1'b1;
                        busy        <= 1'b1;
                        rt_valid    <= 1'b0;
                        early       <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                WAIT: begin
                    // A press during the wait is a false start, even if the
                    // wait completes on the same cycle.
                    if (btn_react) begin
                        r_state     <= EARLY;
                        start_rwait <= 1'b0;
                        busy        <= 1'b0;
                        early       <= 1'b1;
                    end else if (r_waitdone) begin
                        r_state     <= GO;
                        start_rwait <= 1'b0;
                        led_go      <= 1'b1;
                    end
                end
                GO: begin
                    // A press on the ceiling cycle still counts as a result.
                    if (btn_react) begin
                        r_state  <= DONE;
                        led_go   <= 1'b0;
                        busy     <= 1'b0;
                        rt_ms    <= r_ms_cnt;
                        rt_valid <= 1'b1;
                    end else if (r_ms_cnt == C_MAX) begin
                        r_state  <= TIMEOUT;
                        led_go   <= 1'b0;
                        busy     <= 1'b0;
                        rt_ms    <= C_MAX;
                        rt_valid <= 1'b0;
                        timeout  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    start_rwait <= 1'b0;
                    led_go      <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef REACTION_BEST_TIME_EN
    logic [MS_W-1:0] r_best;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_best <= C_MAX;
        end else if (w_in_go && btn_react && (r_ms_cnt < r_best)) begin
            r_best <= r_ms_cnt;
        end
    end

    assign best_ms = r_best;
`else
    assign best_ms = C_MAX;
`endif

endmodule : reaction_ctrl
`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_ctrl
// Description : Self-checking bench for reaction_ctrl with TICK_DIV=4 and
//               MAX_MS=20. A behavioural round model predicts every output
//               each cycle; directed rounds add literal expectations and
//               random stimulus exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_ctrl;

    localparam int TDIV = 4;
    localparam int MAXM = 20;
    localparam int MSW  = 14;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           btn_start = 1'b0;
    logic           btn_react = 1'b0;
    logic           r_waitdone = 1'b0;
    logic           start_rwait, led_go, rt_valid, early, timeout, busy;
    logic [MSW-1:0] rt_ms, best_ms;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: phase 0 = not busy, 1 = waiting, 2 = GO; k = cycles spent in GO.
    int m_phase = 0;
    int m_k     = 0;
    int m_rt    = 0;
    bit m_valid = 0;
    bit m_early = 0;
    bit m_to    = 0;
    int m_best  = MAXM;

    reaction_ctrl #(
        .TICK_DIV (TDIV),
        .MAX_MS   (MAXM),
        .MS_W     (MSW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start   (btn_start),
        .btn_react   (btn_react),
        .r_waitdone  (r_waitdone),
        .start_rwait (start_rwait),
        .led_go      (led_go),
        .rt_ms       (rt_ms),
        .rt_valid    (rt_valid),
        .early       (early),
        .timeout     (timeout),
        .busy        (busy),
        .best_ms     (best_ms)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0; m_k = 0; m_rt = 0; m_valid = 0;
            m_early = 0; m_to = 0; m_best = MAXM;
        end else if (m_phase == 0) begin
            if (btn_start) begin
                m_phase = 1; m_valid = 0; m_early = 0; m_to = 0;
            end
        end else if (m_phase == 1) begin
            if (btn_react) begin
                m_phase = 0; m_early = 1;
            end else if (r_waitdone) begin
                m_phase = 2; m_k = 0;
            end
        end else begin
            if (btn_react) begin
                m_phase = 0; m_rt = m_k / TDIV; m_valid = 1;
`ifdef REACTION_BEST_TIME_EN
                if (m_rt < m_best) m_best = m_rt;
`endif
            end else if (m_k / TDIV == MAXM) begin
                m_phase = 0; m_rt = MAXM; m_valid = 0; m_to = 1;
            end else begin
                m_k = m_k + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start_rwait", int'(start_rwait), int'(m_phase == 1));
            chk("led_go",      int'(led_go),      int'(m_phase == 2));
            chk("busy",        int'(busy),        int'(m_phase != 0));
            chk("rt_ms",       int'(rt_ms),       m_rt);
            chk("rt_valid",    int'(rt_valid),    int'(m_valid));
            chk("early",       int'(early),       int'(m_early));
            chk("timeout",     int'(timeout),     int'(m_to));
            chk("best_ms",     int'(best_ms),     m_best);
        end
    end

    task automatic step(input bit s, input bit r, input bit w);
        btn_start = s; btn_react = r; r_waitdone = w;
        @(negedge clk);
        btn_start = 0; btn_react = 0; r_waitdone = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Runs one round that reacts in GO cycle go_k; returns at the first
    // negedge after the result is captured.
    task automatic round(input int go_k);
        step(1, 0, 0);
        idle(2);
        step(0, 0, 1);
        idle(go_k);
        step(0, 1, 0);
    endtask

    initial begin
        // 1. Normal round
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        chk_en = 1;
        chk("reset start_rwait", int'(start_rwait), 0);
        chk("reset rt_ms", int'(rt_ms), 0);
        chk("reset best_ms", int'(best_ms), 20);
        step(1, 0, 0);
        chk("s1 start_rwait", int'(start_rwait), 1);
        idle(6);
        step(0, 0, 1);
        chk("s1 led_go", int'(led_go), 1);
        chk("s1 start_rwait low", int'(start_rwait), 0);
        idle(22);
        step(0, 1, 0);
        chk("s1 rt_ms", int'(rt_ms), 5);
        chk("s1 rt_valid", int'(rt_valid), 1);
        chk("s1 busy", int'(busy), 0);

        // 2. False start
        step(1, 0, 0);
        idle(2);
        step(0, 1, 0);
        chk("s2 early", int'(early), 1);
        chk("s2 rt_valid", int'(rt_valid), 0);
        chk("s2 led_go", int'(led_go), 0);

        // 3. Simultaneous react and wait-done
        step(1, 0, 0);
        idle(3);
        step(0, 1, 1);
        chk("s3 early", int'(early), 1);
        chk("s3 led_go", int'(led_go), 0);

        // 4. Timeout, late react ignored, restart clears flag
        step(1, 0, 0);
        step(0, 0, 1);
        idle(80);
        chk("s4 not yet timeout", int'(timeout), 0);
        @(negedge clk);
        chk("s4 timeout", int'(timeout), 1);
        chk("s4 rt_ms", int'(rt_ms), 20);
        chk("s4 rt_valid", int'(rt_valid), 0);
        step(0, 1, 0);
        chk("s4 late react", int'(timeout), 1);
        step(1, 0, 0);
        chk("s4 restart timeout", int'(timeout), 0);
        chk("s4 restart wait", int'(start_rwait), 1);

        // 5. Reset mid-GO at ms count 3
        step(0, 0, 1);
        idle(13);
        rst = 0;
        @(negedge clk);
        rst = 1;
        chk("s5 led_go", int'(led_go), 0);
        chk("s5 rt_ms", int'(rt_ms), 0);
        chk("s5 busy", int'(busy), 0);
        step(0, 0, 1);
        chk("s5 waitdone ignored", int'(led_go), 0);

        // 6. Best time across rounds
        round(36);
        chk("s6 rt 9", int'(rt_ms), 9);
`ifdef REACTION_BEST_TIME_EN
        chk("s6 best 9", int'(best_ms), 9);
`else
        chk("s6 best tied 9", int'(best_ms), 20);
`endif
        round(16);
        chk("s6 rt 4", int'(rt_ms), 4);
`ifdef REACTION_BEST_TIME_EN
        chk("s6 best 4", int'(best_ms), 4);
`else
        chk("s6 best tied 4", int'(best_ms), 20);
`endif
        round(48);
        chk("s6 rt 12", int'(rt_ms), 12);
`ifdef REACTION_BEST_TIME_EN
        chk("s6 best 4 kept", int'(best_ms), 4);
`else
        chk("s6 best tied 12", int'(best_ms), 20);
`endif

        // Random phase: react density varies so timeouts also occur.
        for (int blk = 0; blk < 8; blk++) begin
            int rd;
            rd = (blk % 2 == 0) ? 25 : 120;
            for (int i = 0; i < 500; i++) begin
                rst        = ($urandom_range(0, 399) != 0);
                btn_start  = ($urandom_range(0, 14) == 0);
                btn_react  = ($urandom_range(0, rd - 1) == 0);
                r_waitdone = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
        end
        rst = 1; btn_start = 0; btn_react = 0; r_waitdone = 0;
        @(negedge clk);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reaction_ctrl
`default_nettype wire

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
Top-level controller of the human reaction timer; the initiator side of the random-wait handshake.
- Raises start_rwait toward the random-wait counter and consumes its r_waitdone.
- Then lights the GO indicator and measures the player's reaction in milliseconds until btn_react.
- Flags false starts (press before GO) and timeouts; result drives the display path.

Parameters:
TICK_DIV, 100000, clk cycles per millisecond tick (100 MHz clk)
MAX_MS, 9999, reaction count ceiling; reaching it ends the round as timeout
MS_W, 14, width of millisecond count (must hold MAX_MS)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset: rst==0 at a clk rising edge resets the block
btn_start  input  1  debounced single-cycle start pulse
btn_react  input  1  debounced single-cycle reaction pulse
r_waitdone  input  1  random wait complete, from the random-wait counter
start_rwait  output  1  request/hold random wait; level, high only in WAIT
led_go  output  1  GO indicator, high only in GO
rt_ms  output  MS_W  last measured reaction time, ms
rt_valid  output  1  rt_ms holds a valid result
early  output  1  false start flagged
timeout  output  1  MAX_MS reached without reaction
busy  output  1  high in WAIT or GO
best_ms  output  MS_W  best (minimum) valid reaction; see Optional Feature

Behaviour:
- Reset (rst==0 at edge): state IDLE; start_rwait=0, led_go=0, rt_ms=0, rt_valid=0, early=0, timeout=0, busy=0, best_ms=MAX_MS, tick/ms counters 0. Reset mid-round aborts immediately; no result is kept.
- States: IDLE, WAIT, GO, DONE, EARLY, TIMEOUT. All outputs are registered and decoded from the state.
- IDLE/DONE/EARLY/TIMEOUT + btn_start -> WAIT next cycle.
  - Clears rt_valid, early, timeout. rt_ms keeps its old value until overwritten.
- btn_start in WAIT or GO is ignored.
- WAIT: start_rwait=1, held continuously; the random-wait counter runs only while it is high.
  - btn_react -> EARLY; start_rwait drops that same transition.
  - else r_waitdone -> GO; start_rwait=0 and led_go=1 from the next cycle.
  - r_waitdone and btn_react in the same cycle: EARLY wins.
- GO: the tick counter counts 0..TICK_DIV-1. On wrap, ms counter +1.
  - Both counters are cleared on entry to GO.
  - btn_react -> DONE: rt_ms <= ms count (completed ms, floor), rt_valid=1.
  - Press in the first GO cycle gives rt_ms=0.
  - ms count reaching MAX_MS -> TIMEOUT: timeout=1, rt_ms=MAX_MS, rt_valid=0.
  - btn_react on the same cycle as reaching MAX_MS: DONE with rt_ms=MAX_MS wins.
- r_waitdone outside WAIT is ignored. btn_react outside WAIT/GO is ignored.
- EARLY: early=1, rt_valid=0 until the next btn_start.

Optional Feature:
Macro REACTION_BEST_TIME_EN.
- Defined: best_ms register, reset to MAX_MS. On every DONE entry, best_ms <= min(best_ms, captured rt_ms). It persists across rounds and is cleared only by reset.
- Undefined: no register; best_ms tied to MAX_MS constant.

Decomposition:
- Package reaction_pkg: state enum type (IDLE, WAIT, GO, DONE, EARLY, TIMEOUT), default MS_W/MAX_MS constants.
- Sub-module ms_tick_gen (parameter TICK_DIV; ports clk, rst, clr, en, tick).
  - Single-cycle tick every TICK_DIV enabled cycles.
  - clr restarts the count.
  - Instantiated once.

Test Plan:
Sim params for all scenarios: TICK_DIV=4, MAX_MS=20.
1. Normal round: rst low 2 cycles, btn_start -> start_rwait=1 next cycle. Pulse r_waitdone after 7 cycles -> start_rwait=0, led_go=1 next cycle. btn_react after 22 GO cycles -> rt_ms=5, rt_valid=1, busy=0.
2. False start: btn_start, then btn_react 3 cycles later with r_waitdone low -> early=1, start_rwait=0, led_go never 1, rt_valid=0.
3. Simultaneous: btn_react and r_waitdone same cycle in WAIT -> EARLY, led_go stays 0.
4. Timeout: enter GO, no react -> after 80 cycles timeout=1, rt_ms=20, rt_valid=0. A late btn_react is ignored; btn_start -> WAIT with timeout cleared.
5. Reset mid-GO: rst=0 during GO with ms count 3 -> next edge all outputs at reset values; a subsequent r_waitdone pulse is ignored.
6. With REACTION_BEST_TIME_EN: rounds with 9, 4, 12 ms -> best_ms=9, then 4, then 4. Without the macro: best_ms==20 throughout.
